// File: rtl/mem_seq_if.sv
// Handshake and bank-control bundle between the board top and mem_seq_ctrl.
interface mem_seq_if #(parameter int AW = 4);
  logic          start;
  logic          wr_req;
  logic          inc;
  logic          dec;
  logic          sel_in;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] addr_out;
  logic          we_in;
  logic          oe_in;
  logic          we_out;
  logic          oe_out;
  logic          busy;
  logic          done;

  modport master (
    output start, wr_req, inc, dec, sel_in,
    input  addr_in, addr_out, we_in, oe_in, we_out, oe_out, busy, done
  );

  modport slave (
    input  start, wr_req, inc, dec, sel_in,
    output addr_in, addr_out, we_in, oe_in, we_out, oe_out, busy, done
  );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Input/output bank sequencer: manual addressing, single writes and an automatic sweep.
// Optional MEM_SEQ_WRAP_EN makes manual inc/dec wrap instead of saturate.
//
// state   | meaning
// IDLE    | manual control, display bank selected by sel_in
// WR_IN   | one-cycle write of the switch word into the input bank
// SWEEP   | reading input words 0..2**AW-1 into the datapath
// DRAIN   | waiting LAT cycles for the last results to be written
// DONE    | one-cycle completion pulse
module mem_seq_ctrl #(
  parameter int AW  = 4,
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  mem_seq_if.slave bus
);

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WR_IN, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          addr_in_q, addr_in_d;
  logic [AW-1:0]          addr_out_q, addr_out_d;
  logic [CW-1:0]          drain_cnt_q, drain_cnt_d;
  logic [LAT-1:0]         pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0][AW-1:0] pipe_addr_q, pipe_addr_d;
  logic                   we_in_q, we_in_d;
  logic                   oe_in_q, oe_in_d;
  logic                   oe_out_q, oe_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [AW-1:0]          addr_inc, addr_dec;

`ifdef MEM_SEQ_WRAP_EN
  assign addr_inc = addr_in_q + AW'(1);
  assign addr_dec = addr_in_q - AW'(1);
`else
  assign addr_inc = (addr_in_q == ADDR_MAX) ? ADDR_MAX : addr_in_q + AW'(1);
  assign addr_dec = (addr_in_q == '0) ? '0 : addr_in_q - AW'(1);
`endif

  always_comb begin
    state_d     = state_q;
    addr_in_d   = addr_in_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.inc && bus.dec) begin
          addr_in_d = '0;
        end else if (bus.start) begin
          state_d   = S_SWEEP;
          addr_in_d = '0;
        end else if (bus.wr_req) begin
          state_d = S_WR_IN;
        end else if (bus.dec) begin
          addr_in_d = addr_dec;
        end else if (bus.inc) begin
          addr_in_d = addr_inc;
        end
      end
      S_WR_IN: state_d = S_IDLE;
      S_SWEEP: begin
        if (addr_in_q == ADDR_MAX) begin
          state_d     = S_DRAIN;
          drain_cnt_d = CW'(LAT - 1);
        end else begin
          addr_in_d = addr_in_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d   = S_DONE;
          addr_in_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        addr_in_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Delay line standing in for the datapath: each swept read becomes a write LAT cycles later.
    pipe_vld_d     = '0;
    pipe_addr_d    = '0;
    pipe_vld_d[0]  = (state_q == S_SWEEP);
    pipe_addr_d[0] = addr_in_q;
    for (int i = 1; i < LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    we_in_d  = (state_d == S_WR_IN);
    oe_in_d  = ((state_d == S_IDLE) && bus.sel_in) || (state_d == S_SWEEP) || (state_d == S_DRAIN);
    oe_out_d = (state_d == S_IDLE) && !bus.sel_in;
    busy_d   = (state_d == S_WR_IN) || (state_d == S_SWEEP) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);

    if ((state_d == S_SWEEP) || (state_d == S_DRAIN)) begin
      addr_out_d = pipe_addr_d[LAT-1];
    end else if (state_d == S_IDLE) begin
      addr_out_d = addr_in_d;
    end else begin
      addr_out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_in_q   <= '0;
      addr_out_q  <= '0;
      drain_cnt_q <= '0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
      we_in_q     <= 1'b0;
      oe_in_q     <= 1'b0;
      oe_out_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_in_q   <= addr_in_d;
      addr_out_q  <= addr_out_d;
      drain_cnt_q <= drain_cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      we_in_q     <= we_in_d;
      oe_in_q     <= oe_in_d;
      oe_out_q    <= oe_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.addr_in  = addr_in_q;
  assign bus.addr_out = addr_out_q;
  assign bus.we_in    = we_in_q;
  assign bus.oe_in    = oe_in_q;
  assign bus.we_out   = pipe_vld_q[LAT-1];
  assign bus.oe_out   = oe_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench: two controllers (LAT=1 and LAT=3) driven in lockstep.
module tb_mem_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_seq_if #(.AW(4)) b1();
  mem_seq_if #(.AW(4)) b3();

  mem_seq_ctrl #(.AW(4), .LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mem_seq_ctrl #(.AW(4), .LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  typedef struct {int a; int c;} ev_t;
  ev_t q_wo1[$], q_wo3[$], q_wi1[$], q_wi3[$];
  int  q_dn1[$], q_dn3[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    ev_t e;
    if (rst_n) begin
      if (b1.we_out) begin
        chk("lat1 oe_out low during we_out", int'(b1.oe_out), 0);
        chk("lat1 we_out expected", int'(q_wo1.size() > 0), 1);
        if (q_wo1.size() > 0) begin
          e = q_wo1.pop_front();
          chk("lat1 addr_out", int'(b1.addr_out), e.a);
          chk("lat1 we_out cycle", cyc, e.c);
        end
      end
      if (b1.we_in) begin
        chk("lat1 oe_in low during we_in", int'(b1.oe_in), 0);
        chk("lat1 we_in expected", int'(q_wi1.size() > 0), 1);
        if (q_wi1.size() > 0) begin
          e = q_wi1.pop_front();
          chk("lat1 we_in addr", int'(b1.addr_in), e.a);
          chk("lat1 we_in cycle", cyc, e.c);
        end
      end
      if (b1.done) begin
        chk("lat1 done expected", int'(q_dn1.size() > 0), 1);
        if (q_dn1.size() > 0) chk("lat1 done cycle", cyc, q_dn1.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon3
    ev_t e;
    if (rst_n) begin
      if (b3.we_out) begin
        chk("lat3 oe_out low during we_out", int'(b3.oe_out), 0);
        chk("lat3 we_out expected", int'(q_wo3.size() > 0), 1);
        if (q_wo3.size() > 0) begin
          e = q_wo3.pop_front();
          chk("lat3 addr_out", int'(b3.addr_out), e.a);
          chk("lat3 we_out cycle", cyc, e.c);
        end
      end
      if (b3.we_in) begin
        chk("lat3 oe_in low during we_in", int'(b3.oe_in), 0);
        chk("lat3 we_in expected", int'(q_wi3.size() > 0), 1);
        if (q_wi3.size() > 0) begin
          e = q_wi3.pop_front();
          chk("lat3 we_in addr", int'(b3.addr_in), e.a);
          chk("lat3 we_in cycle", cyc, e.c);
        end
      end
      if (b3.done) begin
        chk("lat3 done expected", int'(q_dn3.size() > 0), 1);
        if (q_dn3.size() > 0) chk("lat3 done cycle", cyc, q_dn3.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic drive(input logic s, input logic w, input logic i, input logic d);
    b1.start = s;  b3.start = s;
    b1.wr_req = w; b3.wr_req = w;
    b1.inc = i;    b3.inc = i;
    b1.dec = d;    b3.dec = d;
  endtask

  task automatic set_sel(input logic v);
    b1.sel_in = v;
    b3.sel_in = v;
  endtask

  task automatic pulse(input logic s, input logic w, input logic i, input logic d);
    drive(s, w, i, d);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_addr(input string nm, input int exp);
    chk({nm, " lat1"}, int'(b1.addr_in), exp);
    chk({nm, " lat3"}, int'(b3.addr_in), exp);
  endtask

  initial begin : stim
    int k;
    int exp_dec0;
    int exp_inc16;
`ifdef MEM_SEQ_WRAP_EN
    exp_dec0  = 15;
    exp_inc16 = 0;
`else
    exp_dec0  = 0;
    exp_inc16 = 15;
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    set_sel(1'b1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    #1;
    chk("oe_in before first edge", int'(b1.oe_in), 0);
    tick(1);
    chk("idle oe_in", int'(b1.oe_in), 1);
    chk("idle oe_out", int'(b1.oe_out), 0);
    chk("idle oe_in lat3", int'(b3.oe_in), 1);
    chk_addr("reset addr", 0);

    repeat (3) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_addr("3x inc", 3);
    chk("addr_out mirrors addr_in", int'(b1.addr_out), 3);

    rst_n = 1'b0;
    #1;
    chk_addr("async reset addr", 0);
    chk("async reset oe_in", int'(b1.oe_in), 0);
    chk("async reset addr_out", int'(b1.addr_out), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    repeat (3) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_addr("3x inc again", 3);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    chk_addr("inc&dec clear", 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk_addr("dec at 0", exp_dec0);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (16) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_addr("16x inc", exp_inc16);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_addr("5x inc", 5);

    k = cyc + 1;
    q_wi1.push_back('{a: 5, c: k});
    q_wi3.push_back('{a: 5, c: k});
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wr we_in", int'(b1.we_in), 1);
    chk("wr oe_in", int'(b1.oe_in), 0);
    chk("wr oe_out", int'(b1.oe_out), 0);
    chk("wr busy", int'(b1.busy), 1);
    tick(1);
    chk("wr we_in cleared", int'(b1.we_in), 0);
    chk("wr busy cleared", int'(b1.busy), 0);
    chk("wr idle oe_in back", int'(b1.oe_in), 1);
    chk_addr("wr addr held", 5);

    set_sel(1'b0);
    tick(1);
    chk("sel0 oe_out", int'(b1.oe_out), 1);
    chk("sel0 oe_in", int'(b1.oe_in), 0);

    // Full sweep with ignored pulses and a sel_in change sprinkled in.
    k = cyc + 1;
    for (int i = 0; i < 16; i++) begin
      q_wo1.push_back('{a: i, c: k + 1 + i});
      q_wo3.push_back('{a: i, c: k + 3 + i});
    end
    q_dn1.push_back(k + 17);
    q_dn3.push_back(k + 19);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk_addr("sweep addr after start", 0);
    chk("sweep busy", int'(b1.busy), 1);
    chk("sweep oe_in", int'(b1.oe_in), 1);
    for (int i = 1; i < 16; i++) begin
      drive(i == 8, i == 6, (i == 4) || (i == 10), i == 10);
      if (i == 5) set_sel(1'b1);
      tick(1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_addr("sweep addr step", i);
    end
    tick(2);
    chk("lat1 done level", int'(b1.done), 1);
    chk("lat1 busy at done", int'(b1.busy), 0);
    chk("lat1 addr at done", int'(b1.addr_in), 0);
    chk("lat3 busy in drain", int'(b3.busy), 1);
    chk("lat3 addr in drain", int'(b3.addr_in), 15);
    tick(2);
    chk("lat3 done level", int'(b3.done), 1);
    tick(3);
    chk("post sweep idle oe_in", int'(b1.oe_in), 1);
    chk("post sweep idle oe_in lat3", int'(b3.oe_in), 1);

    // Sweep aborted by reset mid-cycle after edge k+7.
    set_sel(1'b0);
    k = cyc + 1;
    for (int i = 0; i <= 6; i++) q_wo1.push_back('{a: i, c: k + 1 + i});
    for (int i = 0; i <= 4; i++) q_wo3.push_back('{a: i, c: k + 3 + i});
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick(7);
    chk_addr("abort addr before reset", 7);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort we_out lat1", int'(b1.we_out), 0);
    chk("abort we_out lat3", int'(b3.we_out), 0);
    chk("abort oe_in", int'(b1.oe_in), 0);
    chk("abort busy", int'(b3.busy), 0);
    chk_addr("abort addr", 0);
    tick(2);
    rst_n = 1'b1;
    tick(25);
    chk("post abort idle oe_out", int'(b1.oe_out), 1);

    chk("lat1 pending writes", q_wo1.size(), 0);
    chk("lat3 pending writes", q_wo3.size(), 0);
    chk("lat1 pending we_in", q_wi1.size(), 0);
    chk("lat3 pending we_in", q_wi3.size(), 0);
    chk("lat1 pending done", q_dn1.size(), 0);
    chk("lat3 pending done", q_dn3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
